multi_pwm_generator: RTL and testbench

MULTI_PWM_GENERATOR -- requirements
Module: multi_pwm_generator

---
 rtl/multi_pwm_generator.sv | 117 +++++++++++
 tb/tb_multi_pwm_generator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multi_pwm_generator.sv
// Multi-channel PWM generator with debounced per-channel duty up/down buttons.
// Duty changes are buffered in a shadow register and applied at frame boundaries.
module multi_pwm_generator #(
  parameter int CHANNELS      = 4,
  parameter int PERIOD        = 10,
  parameter int DEBOUNCE_DIV  = 2,
  parameter int INIT_DUTY     = 5,
  parameter int PHASE_STAGGER = 0,
  localparam int DUTY_W       = $clog2(PERIOD + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [CHANNELS-1:0]          increase_duty,
  input  logic [CHANNELS-1:0]          decrease_duty,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic [CHANNELS*DUTY_W-1:0]   duty_o
);

  localparam int PRE_W   = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam int PHASE_W = DUTY_W + 1;

  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(DEBOUNCE_DIV - 1);
  localparam logic [DUTY_W-1:0]  CNT_LAST  = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0]  DUTY_MAX  = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0]  DUTY_INIT = DUTY_W'(INIT_DUTY);
  localparam logic [PHASE_W-1:0] PERIOD_P  = PHASE_W'(PERIOD);

  function automatic int phase_offset(input int k);
    return (PHASE_STAGGER != 0) ? (k * PERIOD) / CHANNELS : 0;
  endfunction

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [DUTY_W-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0] s1_inc_q, s1_inc_d, s2_inc_q, s2_inc_d;
  logic [CHANNELS-1:0] s1_dec_q, s1_dec_d, s2_dec_q, s2_dec_d;
  logic [DUTY_W-1:0]   shadow_q [CHANNELS];
  logic [DUTY_W-1:0]   shadow_d [CHANNELS];
  logic [DUTY_W-1:0]   active_q [CHANNELS];
  logic [DUTY_W-1:0]   active_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;

  logic                tick;
  logic                frame_end;
  logic [CHANNELS-1:0] inc_pulse, dec_pulse;
  logic [PHASE_W-1:0]  phase;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    tick      = ena && (presc_q == PRE_LAST);
    frame_end = ena && (cnt_q == CNT_LAST);

    presc_d = presc_q;
    if (ena) presc_d = tick ? '0 : presc_q + PRE_W'(1);

    cnt_d = cnt_q;
    if (ena) cnt_d = frame_end ? '0 : cnt_q + DUTY_W'(1);

    // Two-stage sampler clocked by the slow tick; a pulse marks a debounced rising edge.
    s1_inc_d  = tick ? increase_duty : s1_inc_q;
    s2_inc_d  = tick ? s1_inc_q      : s2_inc_q;
    s1_dec_d  = tick ? decrease_duty : s1_dec_q;
    s2_dec_d  = tick ? s1_dec_q      : s2_dec_q;
    inc_pulse = s1_inc_q & ~s2_inc_q & {CHANNELS{tick}};
    dec_pulse = s1_dec_q & ~s2_dec_q & {CHANNELS{tick}};

    shadow_d = shadow_q;
    active_d = active_q;
    pwm_d    = '0;
    phase    = '0;
    duty_o   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (inc_pulse[k] && !dec_pulse[k] && shadow_q[k] != DUTY_MAX)
        shadow_d[k] = shadow_q[k] + DUTY_W'(1);
      else if (dec_pulse[k] && !inc_pulse[k] && shadow_q[k] != '0)
        shadow_d[k] = shadow_q[k] - DUTY_W'(1);

      if (frame_end) active_d[k] = shadow_q[k];

      phase = {1'b0, cnt_q} + PHASE_W'(phase_offset(k));
      if (phase >= PERIOD_P) phase = phase - PERIOD_P;
      pwm_d[k] = ena && (phase < {1'b0, active_q[k]});

      duty_o[k*DUTY_W +: DUTY_W] = active_q[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      s1_inc_q <= '0;
      s2_inc_q <= '0;
      s1_dec_q <= '0;
      s2_dec_q <= '0;
      pwm_q    <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= DUTY_INIT;
        active_q[k] <= DUTY_INIT;
      end
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      s1_inc_q <= s1_inc_d;
      s2_inc_q <= s2_inc_d;
      s1_dec_q <= s1_dec_d;
      s2_dec_q <= s2_dec_d;
      pwm_q    <= pwm_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_multi_pwm_generator.sv
// Directed bench for multi_pwm_generator: default 4-channel instance plus a
// 2-channel phase-staggered instance sharing clock, reset and enable.
module tb_multi_pwm_generator;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  increase_duty;
  logic [3:0]  decrease_duty;
  logic [3:0]  pwm_out;
  logic [15:0] duty_o;

  logic [1:0]  btn_s;
  logic [1:0]  pwm_s;
  logic [7:0]  duty_s;

  int n_checks = 0;
  int n_fail   = 0;
  int runs     = 0;
  logic [3:0] exp_duty [4];

  multi_pwm_generator dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .increase_duty (increase_duty),
    .decrease_duty (decrease_duty),
    .pwm_out       (pwm_out),
    .duty_o        (duty_o)
  );

  multi_pwm_generator #(.CHANNELS(2), .PHASE_STAGGER(1)) dut_stag (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .increase_duty (btn_s),
    .decrease_duty (btn_s),
    .pwm_out       (pwm_s),
    .duty_o        (duty_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // runs mirrors the number of enabled edges since reset release, i.e. the frame counter.
  task automatic step();
    @(posedge clk);
    if (rst) runs = 0;
    else if (ena) runs++;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [3:0] inc, input logic [3:0] dec);
    increase_duty = inc;
    decrease_duty = dec;
    steps(6);
    increase_duty = '0;
    decrease_duty = '0;
    steps(6);
  endtask

  function automatic logic [15:0] exp_duty_vec();
    return {exp_duty[3], exp_duty[2], exp_duty[1], exp_duty[0]};
  endfunction

  // Align to a frame boundary, then check one full frame of outputs on both instances.
  task automatic check_frame(input string tag);
    logic [3:0] exp_pwm;
    while (runs % 10 != 0) step();
    check({tag, "_duty"}, duty_o, exp_duty_vec());
    for (int j = 0; j < 10; j++) begin
      step();
      for (int k = 0; k < 4; k++) exp_pwm[k] = (j < int'(exp_duty[k]));
      check({tag, "_pwm"}, pwm_out, exp_pwm);
      check({tag, "_stag"}, pwm_s, {(j >= 5), (j < 5)});
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    increase_duty = '0;
    decrease_duty = '0;
    btn_s = '0;
    for (int k = 0; k < 4; k++) exp_duty[k] = 4'd5;

    // Reset with ena high: reset wins.
    steps(3);
    check("rst_pwm", pwm_out, 4'h0);
    check("rst_duty", duty_o, 16'h5555);
    check("rst_stag_duty", duty_s, 8'h55);

    // Release: high starts one cycle later, 5 high / 5 low in phase.
    rst = 1'b0;
    step();
    check("first_pwm", pwm_out, 4'hF);
    check_frame("init_a");
    check_frame("init_b");

    // Hold increase[1] 20 cycles: one increment, applied at the next boundary.
    step();
    increase_duty = 4'b0010;
    steps(8);
    check("inc1_midframe", duty_o, 16'h5555);
    step();
    check("inc1_boundary", duty_o, 16'h5565);
    steps(11);
    increase_duty = '0;
    steps(6);
    exp_duty[1] = 4'd6;
    check_frame("inc1");

    // Seven decrements on channel 2 saturate at 0, then six increments reach 6.
    for (int i = 0; i < 7; i++) press(4'b0000, 4'b0100);
    exp_duty[2] = 4'd0;
    check_frame("dec2_sat");
    for (int i = 0; i < 6; i++) press(4'b0100, 4'b0000);
    exp_duty[2] = 4'd6;
    check_frame("inc2");

    // Channel 3 to full scale, extra press saturates; constant high across the wrap.
    for (int i = 0; i < 6; i++) press(4'b1000, 4'b0000);
    exp_duty[3] = 4'd10;
    check_frame("ch3_full_a");
    check_frame("ch3_full_b");

    // Simultaneous inc and dec leave duty unchanged.
    press(4'b1001, 4'b1001);
    check_frame("both");

    // Drop ena mid-frame for 7 cycles: outputs forced low, counter frozen.
    while (runs % 10 != 3) step();
    ena = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("ena_low_pwm", pwm_out, 4'h0);
      check("ena_low_stag", pwm_s, 2'b00);
    end
    check("ena_low_duty", duty_o, exp_duty_vec());
    ena = 1'b1;
    step();
    check("resume_pwm", pwm_out, 4'hF);
    check_frame("resume");

    // Reset mid-debounce: first sample taken, pulse still pending.
    increase_duty = 4'b0001;
    steps(2);
    rst = 1'b1;
    increase_duty = '0;
    steps(3);
    check("rst2_duty", duty_o, 16'h5555);
    check("rst2_pwm", pwm_out, 4'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) exp_duty[k] = 4'd5;
    steps(20);
    check("rst2_no_late", duty_o, 16'h5555);
    check_frame("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
